// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared BCD counter constants, digit type and clamp helper
package counter_pkg;

  localparam int CNT_DIG_W        = 4;
  localparam int CNT_ONES_MAX_DEF = 9;
  localparam int CNT_TENS_MAX_DEF = 5;

  typedef logic [CNT_DIG_W-1:0] digit_t;

  // Out-of-range preset values saturate to the digit maximum instead of being stored.
  function automatic digit_t clamp_digit(input digit_t val, input digit_t max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with explicit wrap and borrow
module bcd_down_digit
  import counter_pkg::*;
#(
  parameter digit_t MAX = digit_t'(CNT_ONES_MAX_DEF)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   load,
  input  digit_t load_val,
  input  logic   stop,
  output digit_t digit,
  output logic   borrow
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      if (digit == '0) begin
        // stop freezes the digit at zero instead of wrapping to MAX
        if (!stop) begin
          digit <= MAX;
        end
      end else begin
        digit <= digit - digit_t'(1);
      end
    end
  end

  assign borrow = en && (digit == '0);

endmodule

// File: rtl/counter_down_mod60.sv
// rtl/counter_down_mod60.sv - two-digit BCD down-counter; COUNTER_DOWN_STOP_EN selects one-shot mode
module counter_down_mod60
  import counter_pkg::*;
#(
  parameter logic [CNT_DIG_W-1:0] ONES_MAX = CNT_DIG_W'(CNT_ONES_MAX_DEF),
  parameter logic [CNT_DIG_W-1:0] TENS_MAX = CNT_DIG_W'(CNT_TENS_MAX_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_DIG_W-1:0] load_ones,
  input  logic [CNT_DIG_W-1:0] load_tens,
  output logic [CNT_DIG_W-1:0] cnt_ones,
  output logic [CNT_DIG_W-1:0] cnt_tens,
  output logic                 bout,
  output logic                 zero
);

  digit_t ones_load_val;
  digit_t tens_load_val;
  logic   ones_borrow;
  logic   tens_borrow;
  logic   stop;
  logic   bout_set;

  assign ones_load_val = clamp_digit(load_ones, ONES_MAX);
  assign tens_load_val = clamp_digit(load_tens, TENS_MAX);

  assign zero = (cnt_tens == '0) && (cnt_ones == '0);

`ifdef COUNTER_DOWN_STOP_EN
  // One-shot: hold at 00, and flag the 01->00 step rather than the wrap.
  assign stop     = zero;
  assign bout_set = en && !load && (cnt_tens == '0) && (cnt_ones == digit_t'(1));
`else
  assign stop     = 1'b0;
  assign bout_set = en && !load && zero;
`endif

  bcd_down_digit #(
    .MAX(ONES_MAX)
  ) u_ones (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(ones_load_val),
    .stop    (stop),
    .digit   (cnt_ones),
    .borrow  (ones_borrow)
  );

  // Tens advances on the ones borrow, keeping everything on one clock.
  bcd_down_digit #(
    .MAX(TENS_MAX)
  ) u_tens (
    .clk     (clk),
    .rst     (rst),
    .en      (ones_borrow),
    .load    (load),
    .load_val(tens_load_val),
    .stop    (stop),
    .digit   (cnt_tens),
    .borrow  (tens_borrow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bout <= 1'b0;
    end else begin
      bout <= bout_set;
    end
  end

  logic unused_borrow;
  assign unused_borrow = tens_borrow;

endmodule

// File: tb/tb_counter_down_mod60.sv
// tb/tb_counter_down_mod60.sv - scoreboard bench for counter_down_mod60 (both COUNTER_DOWN_STOP_EN builds)
module tb_counter_down_mod60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       bout;
  logic       zero;

  always #5 clk = ~clk;

  counter_down_mod60 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_ones(load_ones),
    .load_tens(load_tens),
    .cnt_ones (cnt_ones),
    .cnt_tens (cnt_tens),
    .bout     (bout),
    .zero     (zero)
  );

  typedef struct {
    string      name;
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
  } exp_s;

  exp_s q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event async_chk;

  task automatic push(input string n, input logic [3:0] t, input logic [3:0] o, input logic b);
    exp_s e;
    e.name = n;
    e.t    = t;
    e.o    = o;
    e.b    = b;
    q.push_back(e);
  endtask

  // Drive one cycle at the falling edge and queue what the next rising edge must show.
  task automatic step(input string n, input logic s_en, input logic s_ld,
                      input logic [3:0] lt, input logic [3:0] lo,
                      input logic [3:0] t, input logic [3:0] o, input logic b);
    @(negedge clk);
    en        = s_en;
    load      = s_ld;
    load_tens = lt;
    load_ones = lo;
    push(n, t, o, b);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_s e;
    logic z;
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        z = (e.t == 4'd0) && (e.o == 4'd0);
        vectors++;
        if (cnt_tens !== e.t || cnt_ones !== e.o || bout !== e.b || zero !== z) begin
          miscompares++;
          $display("FAIL %s: got cnt=%0d%0d bout=%b zero=%b, expected cnt=%0d%0d bout=%b zero=%b",
                   e.name, cnt_tens, cnt_ones, bout, zero, e.t, e.o, e.b, z);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset held, en asserted to show reset dominates
    step("reset0", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("reset1", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("reset2", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

`ifndef COUNTER_DOWN_STOP_EN
    step("wrap", 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1);
    step("wrap_after", 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b0);

    step("load59", 1'b0, 1'b1, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      int v;
      v = (k == 60) ? 59 : 59 - k;
      step("period", 1'b1, 1'b0, 4'd0, 4'd0, 4'(v / 10), 4'(v % 10), (k == 60));
    end
`else
    step("stop_at_zero", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("load10", 1'b0, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 1'b0);
    step("stop_10_09", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0);
`endif

    step("clamp_prio", 1'b1, 1'b1, 4'd7, 4'd12, 4'd5, 4'd9, 1'b0);
    step("clamp_tens", 1'b0, 1'b1, 4'd9, 4'd3, 4'd5, 4'd3, 1'b0);
    step("load00_prio", 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("hold00", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    step("load34", 1'b0, 1'b1, 4'd3, 4'd4, 4'd3, 4'd4, 1'b0);
    step("dec33", 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 4'd3, 1'b0);
    step("dec32", 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 4'd2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push("async_rst", 4'd0, 4'd0, 1'b0);
    ->async_chk;
    #2;
    step("rst_low_edge", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
`ifndef COUNTER_DOWN_STOP_EN
    step("resume_wrap", 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1);
    step("resume_dec", 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 4'd8, 1'b0);
`else
    step("load02", 1'b0, 1'b1, 4'd0, 4'd2, 4'd0, 4'd2, 1'b0);
    step("stop01", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    step("stop00a", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("stop00b", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("stop00c", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("stop00d", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
`endif

    @(negedge clk);
    en = 1'b0;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_down_mod60.md
# counter_down_mod60

Synchronous two-digit BCD down-counter, mod-60 by default (ones digit 9..0, tens digit 5..0), for countdown and timer paths in the counter subsystem. It is the decrementing counterpart of the cascaded mod-60 up-counter. Both digits run on the single system clock, and the tens digit is advanced by an enable rather than a derived clock. It also provides parallel preset, a one-cycle borrow pulse on wrap, and a zero flag.

## Interface
Parameters:
- ONES_MAX, default 4'd9, maximum value of the ones digit. Ones modulus is ONES_MAX+1.
- TENS_MAX, default 4'd5, maximum value of the tens digit. Tens modulus is TENS_MAX+1.

Ports:
- clk, input, 1 bit, system clock. All state updates on the rising edge.
- rst, input, 1 bit, reset. Asynchronous assert, active-low: rst=0 clears all state immediately.
- en, input, 1 bit, count enable. Decrements by one per cycle while high.
- load, input, 1 bit, synchronous preset strobe. Has priority over en.
- load_ones, input, 4 bits, preset value for the ones digit.
- load_tens, input, 4 bits, preset value for the tens digit.
- cnt_ones, output, 4 bits, ones digit, registered.
- cnt_tens, output, 4 bits, tens digit, registered.
- bout, output, 1 bit, registered borrow pulse. High for the one cycle following a 00→wrap decrement.
- zero, output, 1 bit, combinational. High when cnt_tens==0 and cnt_ones==0.

## Operation
- Reset (rst=0): cnt_ones=0, cnt_tens=0, bout=0. The zero output is therefore 1.
- Priority per cycle: load, then en, then hold.
- Load:
  - cnt_ones <= min(load_ones, ONES_MAX); cnt_tens <= min(load_tens, TENS_MAX). Out-of-range values are clamped, never stored.
  - bout <= 0.
- Decrement (en=1, load=0):
  - Ones digit: cnt_ones>0 gives cnt_ones-1. cnt_ones==0 gives ONES_MAX and raises the internal ones borrow.
  - Tens digit: decrements only on ones borrow. cnt_tens>0 gives cnt_tens-1; cnt_tens==0 gives TENS_MAX.
  - bout <= 1 exactly when the pre-edge state is 00. Otherwise bout <= 0.
- Hold (en=0, load=0): digits unchanged, bout <= 0.
- Arithmetic: all comparisons and decrements are 4-bit unsigned. No binary carry out of a digit is ever used; the wrap is explicit.

## Timing
- Decrement latency is 1 cycle: the count changes on the edge where en is sampled high.
- Load latency is 1 cycle: the loaded value is visible on the edge after load is sampled high.
- bout is high in the same cycle the outputs first show the wrapped value (default 59). It is high for exactly one cycle per wrap.
- With en held high continuously, bout has a period of (ONES_MAX+1)*(TENS_MAX+1) cycles, which is 60 by default.
- zero follows the registered digits combinationally. It is valid in the same cycle the digits settle.
- Simultaneous load and en: load wins, no decrement occurs, and bout=0 on the next cycle.
- Reset mid-count: outputs clear asynchronously. Counting resumes from 00 on the first edge after rst deasserts. The next en cycle then wraps and pulses bout.

## Configuration
- COUNTER_DOWN_STOP_EN undefined: free-running modulo behaviour as specified above.
- COUNTER_DOWN_STOP_EN defined: one-shot countdown mode.
  - At 00 with en=1, the digits hold at 00 instead of wrapping.
  - bout pulses once, on the 01→00 transition, meaning it is high in the first cycle that shows 00.
  - Further en cycles at 00 leave bout=0.
  - Load still re-arms the counter.

## Structure
- Shared package counter_pkg holds:
  - the BCD digit width constant, CNT_DIG_W = 4;
  - default modulus constants CNT_ONES_MAX_DEF = 9 and CNT_TENS_MAX_DEF = 5, shared with the up-counter.
- One sub-module, bcd_down_digit, instantiated twice.
  - Parameter: MAX.
  - Ports: clk, rst, en, load, load_val, stop, and outputs digit and borrow.
  - borrow = en && digit==0, combinational.
  - The tens instance's en is the ones instance's borrow.
- The top module holds the bout register, the clamping logic, zero decode, and the stop-mode gating.

## Test plan
- Reset then hold: rst=0 for 3 cycles, then en=0 for 5 cycles. Required: cnt=00, zero=1, bout=0 throughout.
- Wrap: from reset, en=1 for 1 cycle. Required: cnt_tens=5, cnt_ones=9, bout=1 for that cycle only, zero=0.
- Full period: load 5/9, then en=1 for 60 cycles. Required:
  - digits step 59, 58, …, 50, 49, …, 00, 59;
  - exactly one bout pulse, on the 60th edge.
- Load clamp and priority: load=1, en=1, load_tens=7, load_ones=12. Required: next cycle cnt=59, bout=0.
- Async reset mid-count: load 3/4, en=1 for 2 cycles, then drop rst between edges. Required: outputs go to 00 without waiting for a clock edge, and bout=0.
- Stop mode (COUNTER_DOWN_STOP_EN defined): load 0/2, en=1 for 5 cycles. Required: count steps 01, 00, 00, 00, 00; bout=1 only in the first 00 cycle.
